// File: rtl/wshbn_mem_slave.sv
// wshbn_mem_slave: single-port word RAM answering the rd/wr/busy/data_av bus
// one request at a time, responding LATENCY wait states after accept.
module wshbn_mem_slave #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wshbn_rd,
   input  logic        wshbn_wr,
   input  logic [29:0] wshbn_addr,
   input  logic [31:0] wshbn_wdata,
   input  logic [3:0]  wshbn_sel,
   output logic [31:0] wshbn_rdata,
   output logic        wshbn_busy,
   output logic        wshbn_data_av
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t            r_state, w_next;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_rdata;
   logic [3:0]        r_sel;
   logic              r_wr, r_busy, r_data_av;
   logic              w_accept, w_commit;
   logic [31:0]       r_mem [2**ADDR_W];
   always_comb begin
      w_accept = r_state == IDLE && (wshbn_rd || wshbn_wr);
      w_commit = r_state == WAIT && r_cnt == 4'd0;
      w_next   = w_accept ? WAIT : w_commit ? RESP : r_state == WAIT ? WAIT : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= 4'd0;
         r_busy    <= 1'b0;
         r_data_av <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_busy    <= w_next != IDLE;
         r_data_av <= w_commit && !r_wr;
         // write wins over a simultaneous read
         if (w_accept) begin
            r_cnt   <= 4'(LATENCY);
            r_addr  <= wshbn_addr[ADDR_W-1:0];
            r_wdata <= wshbn_wdata;
            r_sel   <= wshbn_sel;
            r_wr    <= wshbn_wr;
         end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
         if (w_commit && !r_wr) r_rdata <= r_mem[r_addr];
      end
   end
   // reset on the commit edge suppresses the write
   always_ff @(posedge clk) begin
      if (!rst && w_commit && r_wr)
         for (int n = 0; n < 4; n++)
            if (r_sel[n]) r_mem[r_addr][8*n +: 8] <= r_wdata[8*n +: 8];
   end
   assign wshbn_rdata   = r_rdata;
   assign wshbn_busy    = r_busy;
   assign wshbn_data_av = r_data_av;
endmodule

// File: tb/tb_wshbn_mem_slave.sv
// tb_wshbn_mem_slave: random and directed bus traffic on a LATENCY=2 and a LATENCY=0
// instance, checked against a word-array model of the memory.
module tb_wshbn_mem_slave;
   logic        clk = 1'b0, rst = 1'b1;
   logic        rd = 1'b0, wr = 1'b0;
   logic [29:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  sel = '0;
   bit          use0 = 1'b0;
   logic [31:0] rdata2, rdata0, o_rdata;
   logic        busy2, busy0, av2, av0, o_busy, o_av;
   logic [31:0] mdl [2][1024];
   bit          vld [2][1024];
   int          n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   wshbn_mem_slave #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .wshbn_rd(rd & !use0), .wshbn_wr(wr & !use0),
      .wshbn_addr(addr), .wshbn_wdata(wdata), .wshbn_sel(sel),
      .wshbn_rdata(rdata2), .wshbn_busy(busy2), .wshbn_data_av(av2));
   wshbn_mem_slave #(.ADDR_W(4), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst), .wshbn_rd(rd & use0), .wshbn_wr(wr & use0),
      .wshbn_addr(addr), .wshbn_wdata(wdata), .wshbn_sel(sel),
      .wshbn_rdata(rdata0), .wshbn_busy(busy0), .wshbn_data_av(av0));
   assign o_rdata = use0 ? rdata0 : rdata2;
   assign o_busy  = use0 ? busy0 : busy2;
   assign o_av    = use0 ? av0 : av2;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask
   function automatic int lat();
      return use0 ? 0 : 2;
   endfunction
   function automatic int idx(input logic [29:0] a);
      return use0 ? int'(a[3:0]) : int'(a[9:0]);
   endfunction
   task automatic bus_op(input bit rd_i, input bit wr_i, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit mid_rd,
                         output logic [31:0] q, output int nb, output int nav, output int pav);
      @(negedge clk);
      rd = rd_i; wr = wr_i; addr = a; wdata = d; sel = s;
      @(posedge clk);
      nb = 0; nav = 0; pav = -1; q = '0;
      for (int j = 1; j <= lat() + 6; j++) begin
         @(negedge clk);
         if (j == 1) begin rd = mid_rd; wr = 1'b0; if (mid_rd) addr = 30'd3; end
         if (j == 3) rd = 1'b0;
         if (o_busy) nb++;
         if (o_av) begin nav++; pav = j; q = o_rdata; end
      end
   endtask
   task automatic do_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s, input bit both);
      logic [31:0] q, m;
      int nb, nav, pav, i;
      bus_op(both, 1'b1, a, d, s, 1'b0, q, nb, nav, pav);
      chk("wr_busy_len", nb, lat() + 2);
      chk("wr_no_av", nav, 0);
      i = idx(a);
      m = 0;
      for (int n = 0; n < 4; n++) if (s[n]) m |= 32'hFF << (8 * n);
      mdl[use0][i] = (mdl[use0][i] & ~m) | (d & m);
      if (s == 4'hF) vld[use0][i] = 1'b1;
   endtask
   task automatic do_rd(input logic [29:0] a, input bit mid);
      logic [31:0] q;
      int nb, nav, pav;
      bus_op(1'b1, 1'b0, a, 32'h0, 4'h0, mid, q, nb, nav, pav);
      chk("rd_busy_len", nb, lat() + 2);
      chk("rd_av_count", nav, 1);
      chk("rd_av_pos", pav, lat() + 2);
      if (vld[use0][idx(a)]) chk("rd_data", q, mdl[use0][idx(a)]);
   endtask
   initial begin
      rd = 1'b1; addr = 30'd5;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         chk("rst_busy", busy2, 0);
         chk("rst_av", av2, 0);
         chk("rst_rdata", rdata2, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("first_accept_busy", busy2, 1);
      rd = 1'b0;
      repeat (8) @(negedge clk);
      do_wr(30'd5, 32'hDEADBEEF, 4'hF, 1'b0);
      do_rd(30'd5, 1'b0);
      do_wr(30'd6, 32'h11223344, 4'hF, 1'b0);
      do_wr(30'd6, 32'hAABBCCDD, 4'h5, 1'b0);
      do_rd(30'd6, 1'b0);
      chk("lanes_model", mdl[0][6], 32'h11BB33DD);
      do_wr(30'd7, 32'h5A5A5A5A, 4'hF, 1'b1);
      do_rd(30'd7, 1'b0);
      do_wr(30'd1024 + 30'd3, 32'hCAFEF00D, 4'hF, 1'b0);
      do_rd(30'd3, 1'b1);
      do_wr(30'd8, 32'h01020304, 4'h0, 1'b0);
      // reset while waiting aborts the write
      do_wr(30'd9, 32'h0BADCAFE, 4'hF, 1'b0);
      @(negedge clk); wr = 1'b1; addr = 30'd9; wdata = 32'h12345678; sel = 4'hF;
      @(posedge clk); @(negedge clk); wr = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_busy", busy2, 0);
      chk("abort_av", av2, 0);
      do_rd(30'd9, 1'b0);
      // reset on the very commit edge
      do_wr(30'd10, 32'h55667788, 4'hF, 1'b0);
      @(negedge clk); wr = 1'b1; addr = 30'd10; wdata = 32'h99999999; sel = 4'hF;
      @(posedge clk); @(negedge clk); wr = 1'b0;
      @(negedge clk); @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("commit_rst_busy", busy2, 0);
      chk("commit_rst_rdata", rdata2, 0);
      do_rd(30'd10, 1'b0);
      for (int k = 0; k < 40; k++) begin
         logic [29:0] a;
         a = (30'($urandom) & 30'h3FFF_FC00) | 30'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0 || !vld[0][idx(a)])
            do_wr(a, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, $urandom_range(0, 3) == 0);
         else do_rd(a, 1'b0);
      end
      use0 = 1'b1;
      do_wr(30'd2, 32'hA5A50F0F, 4'hF, 1'b0);
      do_rd(30'd2, 1'b0);
      for (int k = 0; k < 20; k++) begin
         logic [29:0] a;
         a = 30'($urandom);
         if ($urandom_range(0, 1) == 0 || !vld[1][idx(a)]) do_wr(a, $urandom, 4'($urandom), 1'b0);
         else do_rd(a, 1'b0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/wshbn_mem_slave.md
# wshbn_mem_slave

Word-addressed memory responder for the CPU-side memory controller's Wishbone-style bus: it is the responding end of the rd/wr/busy/data_av handshake that the controller drives as initiator. Holds a single-port word RAM, accepts one read or write at a time, and signals completion after a configurable wait-state count. It stands in for external memory in simulation and FPGA builds and sits between the memory controller's bus port and the top level.

## Interface
Parameters:
- ADDR_W, 10: RAM depth is 2**ADDR_W 32-bit words; legal range 4..16.
- LATENCY, 2: wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wshbn_rd  in  1  read request level, driven by the initiator.
- wshbn_wr  in  1  write request level, driven by the initiator.
- wshbn_addr  in  30  word address, i.e. byte address [31:2].
- wshbn_wdata  in  32  write data.
- wshbn_sel  in  4  byte-lane enables for writes; bit n maps to wdata[8n+7:8n].
- wshbn_rdata  out  32  read data, registered; valid while wshbn_data_av=1 and held until the next read response.
- wshbn_busy  out  1  high from the cycle after accept through the response cycle.
- wshbn_data_av  out  1  single-cycle pulse marking read-data valid.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset values: state=IDLE, wshbn_busy=0, wshbn_data_av=0, wshbn_rdata=0, counter=0. RAM contents are not reset.
- IDLE: at an edge where wshbn_wr|wshbn_rd=1, the block latches addr, wdata, sel and op, loads the counter with LATENCY, and moves to WAIT. Otherwise it stays in IDLE.
- Simultaneous rd and wr in IDLE: the write executes and the read is dropped. No data_av is produced.
- WAIT: when counter=0, the next edge moves the FSM to RESP and performs the RAM access. Otherwise the counter decrements.
  - Write: each lane with sel[n]=1 is updated; lanes with sel[n]=0 are untouched. sel=0000 is a legal no-op write.
  - Read: the full word is loaded into wshbn_rdata; sel is ignored.
- RESP: lasts exactly one cycle. wshbn_data_av=1 only for reads. The next edge returns the FSM to IDLE.
- Requests seen in WAIT or RESP are ignored. The initiator must not issue a new request while busy=1.
- Address: only wshbn_addr[ADDR_W-1:0] is used. Upper bits alias, so there is no error response.
- Reset mid-operation forces IDLE in the next cycle and aborts the transaction: no data_av, and no write if the commit edge has not yet occurred. A write commit and a reset on the same edge leave the RAM unwritten, because reset wins.

## Timing
- Let edge k be the accept edge.
- busy is high during cycles k+1 .. k+LATENCY+2, i.e. LATENCY+2 cycles.
- The RAM access happens at edge k+LATENCY+1.
- data_av is high during the cycle after edge k+LATENCY+1, together with valid rdata.
- The FSM reaches IDLE after edge k+LATENCY+2. The earliest next accept is edge k+LATENCY+3.
- LATENCY=0: the response appears in the cycle after edge k+1 and busy lasts 2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles with rd=1 → busy=0, data_av=0, rdata=0 throughout; the first accept happens on the first edge with rst=0.
- LATENCY=2: write 0xDEADBEEF to addr 5 with sel=1111, then read addr 5 → busy high 4 cycles each; data_av pulses exactly once, 3 edges after the read accept; rdata=0xDEADBEEF.
- Byte lanes: write 0x11223344 with sel=1111, then write 0xAABBCCDD with sel=0101, then read → 0x11BB33DD.
- Simultaneous rd=wr=1 with wdata 0x5A5A5A5A to addr 7 → no data_av pulse; a subsequent read of addr 7 returns 0x5A5A5A5A.
- Read requested while busy, then alias: issue rd to addr 3 mid-WAIT → it is ignored (one data_av only). Write addr 2**ADDR_W+3 with 0xCAFEF00D, read addr 3 → 0xCAFEF00D.
- Reset mid-op: write 0x12345678 to addr 9, assert rst while in WAIT → no commit; after reset, a read of addr 9 returns its prior value. With LATENCY=0, busy lasts exactly 2 cycles.
